mux_arb_reg: RTL and testbench
==============================

# mux_arb_reg

Parametrised successor to the team's combinational 4:1 mux: an N-channel, wd-bit registered multiplexer with per-channel valid/ready handshakes and a one-entry output register. It runs in one of two modes, selected at run time: fixed select (as the combinational mux) or round-robin arbitration. It sits between several producer streams and a single consumer, and adds exactly one cycle of latency at full throughput.

## Interface
Parameters:
- wd, 4: data width per channel, >= 1.
- n, 4: channel count, >= 2. The localparam cw = $clog2(n) gives the channel-index width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_data  input  n*wd  flattened channel data; channel i occupies bits [i*wd +: wd].
- in_valid  input  n  per-channel valid.
- in_ready  output  n  per-channel ready; combinational.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  cw  channel index used in mode 0.
- out_data  output  wd  registered data.
- out_valid  output  1  registered valid.
- out_ready  input  1  consumer ready.
- out_ch  output  cw  index of the channel that supplied out_data.

## Operation
- Clock and reset: one clock (clk); asynchronous active-low reset (rst_n).
- Load enable: load = !out_valid || out_ready. The output register accepts a beat when it is empty or is being drained in the same cycle.
- Grant in mode 0: channel sel is granted when in_valid[sel] = 1. If sel >= n (non-power-of-two n), there is no grant.
- Grant in mode 1: scan the channels from ptr upward, modulo n. The first channel with in_valid set is granted. With no valid channel there is no grant.
- Handshake outputs: in_ready[i] = load && grant[i]. At most one bit of in_ready is set per cycle; all bits are 0 when there is no grant.
- Transfer on channel i: in_valid[i] && in_ready[i]. On the next edge the block sets out_data <= channel i data, out_ch <= i and out_valid <= 1.
- Load with no grant: out_valid <= 0. out_data and out_ch hold their previous values.
- Stall (out_valid && !out_ready): out_data, out_ch and out_valid hold stable; every in_ready bit is 0.
- Round-robin pointer ptr (cw bits, internal): on each mode-1 transfer on channel i, ptr <= (i + 1) mod n, with explicit wrap for non-power-of-two n.
  - ptr does not change in mode 0 or when no transfer occurs.
- Fairness: in mode 1, with every channel continuously valid, grants go 0,1,...,n-1,0,... Each waiting channel is served within n transfers.
- Mode or sel changes are sampled combinationally and affect the current cycle's grant. A beat already in the output register is unaffected.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_ch = 0, ptr = 0. in_ready is 0 while reset is held, because the grant logic is gated.
- Reset mid-operation: the register contents are discarded immediately (asynchronous), with no partial beat.
- Latency: 1 cycle from an input transfer to out_valid.
- Throughput: 1 beat per cycle while out_ready = 1.
- Combinational paths: out_ready, in_valid, mode and sel each reach in_ready combinationally. No path exists from in_data to any output except through the register.
- Simultaneous events: drain and load in the same cycle is a legal back-to-back transfer. With all channels valid in mode 1, only the channel at or after ptr is granted.
- Wrap-around: with ptr = n-1 and a transfer on channel n-1, ptr becomes 0.

## Test plan
- Reset: assert rst_n = 0 mid-stream with out_valid = 1. Required: out_valid, out_data, out_ch and ptr are all 0 immediately; in_ready = 0 until release.
- Mode 0 select sweep:
  - Stimulus: wd = 4, n = 4; in_data = {15,7,3,1}; all valid; out_ready = 1; sel stepping 0,1,2,3 one per cycle.
  - Required: out_data is 1,3,7,15 and out_ch is 0,1,2,3, each one cycle after its sel value.
- Mode 1 fairness:
  - Stimulus: all four channels valid continuously; out_ready = 1.
  - Required: out_ch sequence 0,1,2,3,0,1; exactly one in_ready bit set per cycle.
- Mode 1 sparse: only channels 1 and 3 valid, starting from ptr = 2. Required: grants alternate 3,1,3,1; ptr values 0,2,0,2.
- Backpressure: out_ready = 0 for 3 cycles while out_valid = 1 with out_data = 7. Required: out_data stays 7, out_ch stays 2, and in_ready = 0 throughout; the next beat appears 1 cycle after out_ready returns to 1.
- Idle and invalid select:
  - Stimulus 1: in_valid = 0 with out_ready = 1. Required: out_valid drops to 0 next cycle; out_data holds its last value.
  - Stimulus 2: n = 3 with sel = 3 in mode 0. Required: no grant and in_ready = 0.

Source files
------------

// File: rtl/mux_arb_reg.sv
// mux_arb_reg: n-channel registered mux with valid/ready handshakes, fixed-select or round-robin grant.
module mux_arb_reg #(
   parameter int wd = 4,
   parameter int n = 4,
   localparam int cw = $clog2(n)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [n*wd-1:0] in_data,
   input  logic [n-1:0]    in_valid,
   output logic [n-1:0]    in_ready,
   input  logic            mode,
   input  logic [cw-1:0]   sel,
   output logic [wd-1:0]   out_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [cw-1:0]   out_ch
);
   logic          load;
   logic          xfer;
   logic          gnt_vld;
   logic [cw-1:0] gnt_idx;
   logic [cw:0]   scan;
   logic [cw-1:0] c;
   logic [wd-1:0] data_q, data_d;
   logic [cw-1:0] ch_q, ch_d;
   logic [cw-1:0] ptr_q, ptr_d;
   logic          valid_q, valid_d;

   assign load = !valid_q || out_ready;
   assign xfer = load && gnt_vld && rst_n;

   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      scan = '0;
      c = '0;
      if (!mode) begin
         for (int i = 0; i < n; i++) begin
            if (sel == cw'(i) && in_valid[i]) begin
               gnt_vld = 1'b1;
               gnt_idx = cw'(i);
            end
         end
      end else begin
         // first valid channel at or after ptr, wrapping explicitly for non-power-of-two n
         for (int k = 0; k < n; k++) begin
            scan = {1'b0, ptr_q} + (cw+1)'(k);
            scan = (scan >= (cw+1)'(n)) ? scan - (cw+1)'(n) : scan;
            c = scan[cw-1:0];
            if (!gnt_vld && in_valid[c]) begin
               gnt_vld = 1'b1;
               gnt_idx = c;
            end
         end
      end
   end

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < n; i++) in_ready[i] = xfer && gnt_idx == cw'(i);
   end

   always_comb begin
      valid_d = load ? gnt_vld : valid_q;
      data_d = xfer ? in_data[int'(gnt_idx)*wd +: wd] : data_q;
      ch_d = xfer ? gnt_idx : ch_q;
      ptr_d = (xfer && mode) ? ((int'(gnt_idx) == n-1) ? '0 : gnt_idx + 1'b1) : ptr_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q <= '0;
         ch_q <= '0;
         ptr_q <= '0;
      end else begin
         valid_q <= valid_d;
         data_q <= data_d;
         ch_q <= ch_d;
         ptr_q <= ptr_d;
      end
   end

   assign out_data = data_q;
   assign out_valid = valid_q;
   assign out_ch = ch_q;
endmodule

// File: tb/tb_mux_arb_reg.sv
// tb_mux_arb_reg: directed and randomized checks of mux_arb_reg against a queue-free behavioural model.
module tb_mux_arb_reg;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] in_data = '0;
   logic [3:0]  in_valid = '0;
   logic [3:0]  in_ready;
   logic        mode = 1'b0;
   logic [1:0]  sel = '0;
   logic [3:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [1:0]  out_ch;

   logic [11:0] d3_data = '0;
   logic [2:0]  d3_valid = '0;
   logic [2:0]  d3_ready;
   logic        d3_mode = 1'b0;
   logic [1:0]  d3_sel = '0;
   logic [3:0]  d3_out_data;
   logic        d3_out_valid;
   logic [1:0]  d3_out_ch;

   int tests = 0;
   int fails = 0;
   int m_ptr = 0, m_ch = 0, m_data = 0;
   logic m_valid = 1'b0;

   mux_arb_reg #(.wd(4), .n(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .sel(sel), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_ch(out_ch)
   );

   mux_arb_reg #(.wd(4), .n(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_data(d3_data), .in_valid(d3_valid), .in_ready(d3_ready),
      .mode(d3_mode), .sel(d3_sel), .out_data(d3_out_data), .out_valid(d3_out_valid), .out_ready(1'b1),
      .out_ch(d3_out_ch)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // the spec's grant rule: fixed select, or first valid channel counting up from ptr modulo 4
   function automatic int mgrant();
      if (!mode) return in_valid[sel] ? int'(sel) : -1;
      for (int k = 0; k < 4; k++)
         if (in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
      return -1;
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_ch = 0; m_data = 0; m_valid = 1'b0;
   endtask

   task automatic cyc();
      int g;
      logic ld;
      logic [3:0] er;
      #1;
      g = mgrant();
      ld = !m_valid || out_ready;
      er = (ld && g >= 0) ? 4'(1 << g) : 4'b0;
      chk("in_ready", 32'(in_ready), 32'(er));
      @(posedge clk);
      if (ld) begin
         m_valid = (g >= 0);
         if (g >= 0) begin
            m_data = int'(in_data[g*4 +: 4]);
            m_ch = g;
            if (mode) m_ptr = (g + 1) % 4;
         end
      end
      #1;
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_ch", 32'(out_ch), 32'(m_ch));
      chk("ptr", 32'(dut.ptr_q), 32'(m_ptr));
      @(negedge clk);
   endtask

   initial begin
      int sw[4] = '{1, 3, 7, 15};
      int fair[6] = '{0, 1, 2, 3, 0, 1};
      int sp_g[4] = '{3, 1, 3, 1};
      int sp_p[4] = '{0, 2, 0, 2};
      int rr3[4] = '{0, 1, 2, 0};
      in_valid = 4'hF;
      in_data = 16'hF731;
      @(negedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_ch", 32'(out_ch), 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         cyc();
         chk("sweep_data", 32'(out_data), 32'(sw[s]));
         chk("sweep_ch", 32'(out_ch), 32'(s));
      end

      mode = 1'b1;
      for (int s = 0; s < 6; s++) begin
         cyc();
         chk("fair_ch", 32'(out_ch), 32'(fair[s]));
         chk("fair_onehot", 32'($countones(in_ready)), 1);
      end

      in_valid = 4'b1010;
      for (int s = 0; s < 4; s++) begin
         cyc();
         chk("sparse_ch", 32'(out_ch), 32'(sp_g[s]));
         chk("sparse_ptr", 32'(dut.ptr_q), 32'(sp_p[s]));
      end

      mode = 1'b0; sel = 2'd2; in_valid = 4'hF;
      cyc();
      chk("bp_first", 32'(out_data), 7);
      out_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         cyc();
         chk("bp_data", 32'(out_data), 7);
         chk("bp_ch", 32'(out_ch), 2);
         chk("bp_ready", 32'(in_ready), 0);
      end
      out_ready = 1'b1; sel = 2'd3;
      cyc();
      chk("bp_next", 32'(out_data), 15);

      in_valid = 4'h0;
      cyc();
      chk("idle_valid", 32'(out_valid), 0);
      chk("idle_data", 32'(out_data), 15);

      mode = 1'b1; in_valid = 4'hF;
      cyc();
      cyc();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("mid_rst_valid", 32'(out_valid), 0);
      chk("mid_rst_data", 32'(out_data), 0);
      chk("mid_rst_ch", 32'(out_ch), 0);
      chk("mid_rst_ptr", 32'(dut.ptr_q), 0);
      chk("mid_rst_ready", 32'(in_ready), 0);
      @(posedge clk);
      #1;
      chk("mid_rst_ready_hold", 32'(in_ready), 0);
      chk("mid_rst_valid_hold", 32'(out_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      chk("post_rst_ch", 32'(out_ch), 0);

      d3_data = 12'hA5C; d3_valid = 3'b111; d3_mode = 1'b0; d3_sel = 2'd3;
      #1;
      chk("n3_sel3_ready", 32'(d3_ready), 0);
      cyc();
      chk("n3_sel3_valid", 32'(d3_out_valid), 0);
      d3_sel = 2'd2;
      #1;
      chk("n3_sel2_ready", 32'(d3_ready), 32'b100);
      cyc();
      chk("n3_sel2_data", 32'(d3_out_data), 32'hA);
      chk("n3_sel2_ch", 32'(d3_out_ch), 2);
      d3_mode = 1'b1;
      for (int s = 0; s < 4; s++) begin
         cyc();
         chk("n3_rr_ch", 32'(d3_out_ch), 32'(rr3[s]));
         if (s == 2) chk("n3_wrap_ptr", 32'(dut3.ptr_q), 0);
      end

      for (int s = 0; s < 400; s++) begin
         in_valid = 4'($urandom);
         in_data = 16'($urandom);
         mode = 1'($urandom);
         sel = 2'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
